// File: rtl/button_debouncer_if.sv
// ----------------------------------------------------------------------------
// button_debouncer_if
//   Signal bundle between a raw push-button source and the debouncer.
//
//   raw_in        raw, asynchronous button/switch level (driven by the master)
//   level_out     debounced level, 1 = pressed (driven by the debouncer)
//   busy          1 while a candidate level change is being timed
//   glitch_count  8-bit saturating rejected-bounce count; present only when
//                 DEBOUNCE_GLITCH_CNT_EN is defined
//
//   master : the button/source side (drives raw_in, observes the results)
//   slave  : the debouncer side
// ----------------------------------------------------------------------------
interface button_debouncer_if;

    logic       raw_in;
    logic       level_out;
    logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_count;

    modport master (
        output raw_in,
        input  level_out,
        input  busy,
        input  glitch_count
    );

    modport slave (
        input  raw_in,
        output level_out,
        output busy,
        output glitch_count
    );
`else
    modport master (
        output raw_in,
        input  level_out,
        input  busy
    );

    modport slave (
        input  raw_in,
        output level_out,
        output busy
    );
`endif

endinterface : button_debouncer_if

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//   Turns one raw, asynchronous push-button/switch input into a clean,
//   synchronous level for the rising-edge one-shot stage downstream.
//
//   raw_in -> 2-FF synchronizer -> polarity normalize -> stability FSM
//          -> level_out
//
//   A new level is accepted only after the normalized sample has held it for
//   STABLE_CYCLES consecutive clocks. With the raw value held, level_out
//   changes on the (STABLE_CYCLES+2)-th edge, counting the edge at which the
//   first synchronizer flop captures the new value as edge 1.
//
// Parameters
//   STABLE_CYCLES  consecutive samples needed to accept a level (>= 2)
//   ACTIVE_LOW     1: raw_in = 0 means pressed
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   bus (slave)    raw_in, level_out, busy [, glitch_count]
//
// Configuration macro
//   DEBOUNCE_GLITCH_CNT_EN  adds the 8-bit saturating glitch_count register,
//                           incremented on every rejected bounce and cleared
//                           only by reset.
// ----------------------------------------------------------------------------
module button_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    button_debouncer_if.slave bus
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("button_debouncer: STABLE_CYCLES must be >= 2");
    end

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer, reset to the idle (not pressed) raw level
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= bus.raw_in;
            sync2 <= sync1;
        end
    end

    // Normalized sample: 1 = pressed regardless of button polarity
    assign s = sync2 ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Stability FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             busy_q;
    logic             busy_d;

    // State register; the outputs are registered from the next state so
    // that they change on the same edge as the state and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. A sample reverting on the edge where the count
    // would complete is checked first, so the revert wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode of the next state
    always_comb begin
        level_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_d)
            STABLE_LOW:  begin level_d = 1'b0; busy_d = 1'b0; end
            WAIT_HIGH:   begin level_d = 1'b0; busy_d = 1'b1; end
            STABLE_HIGH: begin level_d = 1'b1; busy_d = 1'b0; end
            WAIT_LOW:    begin level_d = 1'b1; busy_d = 1'b1; end
            default:     begin level_d = 1'b0; busy_d = 1'b0; end
        endcase
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // ------------------------------------------------------------------
    // Rejected-bounce counter, saturating at 255
    // ------------------------------------------------------------------
    logic       glitch_event;
    logic [7:0] glitch_q;

    always_comb begin
        glitch_event = ((state_q == WAIT_HIGH) && (state_d == STABLE_LOW)) ||
                       ((state_q == WAIT_LOW)  && (state_d == STABLE_HIGH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= '0;
        end else if (glitch_event && (glitch_q != '1)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign bus.glitch_count = glitch_q;
`endif

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_button_debouncer
//   Directed-vector bench for button_debouncer. Two instances run side by
//   side: dut0 (active-high button) and dut1 (ACTIVE_LOW = 1). Each vector
//   entry drives reset/raw_in for one clock; the hand-computed level/busy
//   values expected after that edge are pushed into a per-DUT queue and a
//   separate monitor pops and compares them on the following falling edge.
// ----------------------------------------------------------------------------
module tb_button_debouncer;

    logic clk;
    logic reset;

    button_debouncer_if bif0 ();
    button_debouncer_if bif1 ();

    button_debouncer #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif0.slave)
    );

    button_debouncer #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic  lvl;
        logic  bsy;
        int    g;
        string nm;
        int    idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;
    int gexp  = 0;

    function automatic logic bit_of(input byte c);
        return (c == "1");
    endfunction

    task automatic cmp(input string nm, input int idx, input string what,
                       input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s[%0d] %s: got %0d want %0d", nm, idx, what, act, req);
        end
    endtask

    // Monitor: compare each queued expectation against the DUT outputs
    always @(negedge clk) begin
        exp_t e;
        while (q0.size() > 0) begin
            e = q0.pop_front();
            cmp(e.nm, e.idx, "level_out", int'(bif0.level_out === 1'b1) + 2 * int'($isunknown(bif0.level_out)), int'(e.lvl));
            cmp(e.nm, e.idx, "busy", int'(bif0.busy === 1'b1) + 2 * int'($isunknown(bif0.busy)), int'(e.bsy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            cmp(e.nm, e.idx, "glitch_count", int'(bif0.glitch_count), e.g);
`endif
        end
        while (q1.size() > 0) begin
            e = q1.pop_front();
            cmp(e.nm, e.idx, "level_out", int'(bif1.level_out === 1'b1) + 2 * int'($isunknown(bif1.level_out)), int'(e.lvl));
            cmp(e.nm, e.idx, "busy", int'(bif1.busy === 1'b1) + 2 * int'($isunknown(bif1.busy)), int'(e.bsy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            cmp(e.nm, e.idx, "glitch_count", int'(bif1.glitch_count), e.g);
`endif
        end
    end

    // Character i of each string applies to clock edge i+1: rs/r0/r1 are
    // driven before that edge, l*/b* are the outputs expected after it.
    // ginc is the vector index whose edge rejects a bounce on dut0.
    task automatic run_vec(input string nm, input string rs,
                           input string r0, input string l0, input string b0,
                           input string r1, input string l1, input string b1,
                           input int ginc);
        for (int i = 0; i < r0.len(); i++) begin
            @(negedge clk);
            reset       = bit_of(rs[i]);
            bif0.raw_in = bit_of(r0[i]);
            bif1.raw_in = bit_of(r1[i]);
            @(posedge clk);
            #1;
            if (bit_of(rs[i]))
                gexp = 0;
            else if (i == ginc && gexp < 255)
                gexp = gexp + 1;
            q0.push_back('{lvl: bit_of(l0[i]), bsy: bit_of(b0[i]), g: gexp,
                           nm: {nm, "/dut0"}, idx: i});
            q1.push_back('{lvl: bit_of(l1[i]), bsy: bit_of(b1[i]), g: 0,
                           nm: {nm, "/dut1"}, idx: i});
        end
    endtask

    initial begin
        reset       = 1'b1;
        bif0.raw_in = 1'b0;
        bif1.raw_in = 1'b1;

        // Reset for two cycles, then idle and stable
        run_vec("reset_idle", "110000000000",
                "000000000000", "000000000000", "000000000000",
                "111111111111", "000000000000", "000000000000", -1);

        // Press held: busy from edge 3, level_out at edge 6
        run_vec("press", "00000000",
                "11111111", "00000111", "00111000",
                "11111111", "00000000", "00000000", -1);

        // Release with a bounce: 0,0,1 then 0 held; falls 6 edges after the last 1->0
        run_vec("release_bounce", "00000000000",
                "00100000000", "11111111000", "00110111000",
                "11111111111", "00000000000", "00000000000", 4);

        // Three-clock pulse: revert lands on the completing edge and is rejected;
        // repeated until the glitch counter saturates
        for (int n = 0; n < 300; n++) begin
            run_vec("short_pulse", "00000000",
                    "11100000", "00000000", "00111000",
                    "11111111", "00000000", "00000000", 5);
        end

        // Reset mid WAIT_HIGH with the button held
        run_vec("reset_mid_wait", "000100000000",
                "111111111111", "000000000111", "001000111000",
                "111111111111", "000000000000", "000000000000", -1);

        // Active-low instance: press is raw_in 1->0
        run_vec("active_low", "1000000000",
                "0000000000", "0000000000", "0000000000",
                "1000000000", "0000001111", "0001110000", -1);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q0.size() + q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_button_debouncer
